param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
// - Parametrised LIFO stack with occupancy tracking, full/empty flags and sticky error flags.
// - Generalises the simple circular stack: selectable circular-overwrite or saturating mode.
// - Also adds a non-destructive top-of-stack peek and a qualified pop-data output.
// - Used as a return/data stack in small stack-machine cores; single clock domain.
// PARAMETERS
// - STACK_WIDTH      18  bit width of one stack word
// - STACK_ADDR_BITS  4   log2 of depth; DEPTH = 2**STACK_ADDR_BITS words (>=1)
// - WRAP_MODE        1   1: push when full overwrites the oldest entry (circular); 0: push when full is dropped
// PORTS
// - i_clk        in   1                  clock, all state updates on rising edge
// - i_rst        in   1                  reset, asynchronous, active-high
// - i_push       in   1                  push i_data this cycle
// - i_pop        in   1                  pop the top-of-stack word this cycle
// - i_data       in   STACK_WIDTH        word to push
// - i_clr_err    in   1                  synchronous clear of o_overflow/o_underflow
// - o_pop_data   out  STACK_WIDTH        word removed by the last accepted pop (registered)
// - o_pop_valid  out  1                  1-cycle pulse: o_pop_data updated this cycle
// - o_tos        out  STACK_WIDTH        current top-of-stack (peek); 0 when empty
// - o_count      out  STACK_ADDR_BITS+1  number of valid entries, 0..DEPTH
// - o_empty      out  1                  o_count == 0
// - o_full       out  1                  o_count == DEPTH
// - o_overflow   out  1                  sticky: push attempted while full
// - o_underflow  out  1                  sticky: pop-only attempted while empty
// BEHAVIOUR
// - Reset (async, i_rst=1): sp=0, count=0, o_pop_data=0, o_pop_valid=0, o_overflow=0, o_underflow=0.
//   Memory contents are not reset; o_tos=0, o_empty=1, o_full=0.
// - Storage: DEPTH-word array. sp = next write address (STACK_ADDR_BITS wide, wraps mod DEPTH).
//   top = sp-1 mod DEPTH. All pointer arithmetic is done at STACK_ADDR_BITS width.
// - o_tos = mem[top] combinationally when count>0, else 0; it reflects an accepted push on the next cycle.
// - o_pop_valid is 0 in every cycle not listed below.
// - Push only (i_push & !i_pop):
//   - not full: mem[sp]<=i_data, sp<=sp+1, count<=count+1.
//   - full & WRAP_MODE=1: mem[sp]<=i_data, sp<=sp+1, count stays DEPTH; oldest word is lost; o_overflow<=1.
//   - full & WRAP_MODE=0: no state change, o_overflow<=1.
// - Pop only (!i_push & i_pop):
//   - not empty: o_pop_data<=mem[top], o_pop_valid<=1, sp<=sp-1, count<=count-1.
//   - empty: no pointer/data change, o_pop_valid<=0, o_underflow<=1.
// - Push and pop together:
//   - not empty (replace): o_pop_data<=mem[top], o_pop_valid<=1, mem[top]<=i_data; sp and count unchanged; no error.
//   - empty (bypass): o_pop_data<=i_data, o_pop_valid<=1, stack unchanged; no error.
// - Neither: hold all state.
// - Error flags: set by the conditions above and held until i_clr_err.
//   If an error sets in the same cycle as i_clr_err, set wins.
// - Latency: pop data is available 1 cycle after the pop cycle. A pop in the cycle after a push returns that pushed word.
// - Reset mid-operation: discards all entries immediately; a push/pop asserted during reset is ignored.
// TESTING
// - Reset, then push 0x00001,0x00002,0x00003 -> o_count=3, o_tos=0x00003; pop x3 -> o_pop_data 3,2,1 with o_pop_valid each cycle; o_empty=1.
// - Pop when empty -> o_pop_valid=0, o_underflow=1, o_count=0; i_clr_err=1 for 1 cycle -> o_underflow=0.
// - WRAP_MODE=1, DEPTH=16: push 1..17 -> o_full=1, o_count=16, o_overflow=1, o_tos=17; pop x16 -> 17..2 (1 lost).
// - WRAP_MODE=0: push 1..17 -> o_count=16, o_tos=16, o_overflow=1; pops return 16..1.
// - Push 0xA then push+pop 0xB -> o_pop_data=0xA, o_count=1, o_tos=0xB; push+pop 0xC on empty stack -> o_pop_data=0xC, o_count=0.
// - Push 5 words, assert i_rst asynchronously between edges -> outputs reset at once: o_count=0, o_empty=1, flags 0.

Source files
------------

// File: rtl/param_stack.sv
// ----------------------------------------------------------------------------
// param_stack
// Parametrised LIFO stack with occupancy tracking, full/empty flags and sticky
// error flags. It can either overwrite the oldest entry when pushed while full
// (circular) or drop the push (saturating). It also provides a
// non-destructive top-of-stack peek and a registered, qualified pop-data
// output. Everything runs in a single clock domain.
//
// Parameters
//   STACK_WIDTH      width of one stack word
//   STACK_ADDR_BITS  log2 of depth (must be >= 1); DEPTH = 2**STACK_ADDR_BITS
//   WRAP_MODE        1: push when full overwrites the oldest entry
//                    0: push when full is dropped
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_push       push i_data this cycle
//   i_pop        pop top-of-stack this cycle
//   i_data       word to push
//   i_clr_err    synchronous clear of the sticky error flags
//   o_pop_data   word removed by the last accepted pop (registered)
//   o_pop_valid  1-cycle pulse: o_pop_data updated this cycle
//   o_tos        current top-of-stack peek, 0 when empty
//   o_count      number of valid entries, 0..DEPTH
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
//   o_overflow   sticky: push attempted while full
//   o_underflow  sticky: pop-only attempted while empty
// ----------------------------------------------------------------------------
module param_stack #(
  parameter int STACK_WIDTH     = 18,
  parameter int STACK_ADDR_BITS = 4,
  parameter int WRAP_MODE       = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [STACK_WIDTH-1:0]     i_data,
  input  logic                       i_clr_err,
  output logic [STACK_WIDTH-1:0]     o_pop_data,
  output logic                       o_pop_valid,
  output logic [STACK_WIDTH-1:0]     o_tos,
  output logic [STACK_ADDR_BITS:0]   o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int DEPTH = 2 ** STACK_ADDR_BITS;
  localparam int CW    = STACK_ADDR_BITS + 1;
  localparam logic [CW-1:0]              DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]              ONE_C   = CW'(1);
  localparam logic [STACK_ADDR_BITS-1:0] ONE_A   = STACK_ADDR_BITS'(1);

  logic [STACK_WIDTH-1:0]     mem [DEPTH];
  logic [STACK_ADDR_BITS-1:0] sp;
  logic [STACK_ADDR_BITS-1:0] sp_nxt;
  logic [STACK_ADDR_BITS-1:0] top;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_nxt;
  logic                       is_empty;
  logic                       is_full;
  logic                       wr_en;
  logic [STACK_ADDR_BITS-1:0] wr_addr;
  logic [STACK_WIDTH-1:0]     pop_data_nxt;
  logic                       pop_valid_nxt;
  logic                       ovf_set;
  logic                       unf_set;

  // Top entry sits just below the write pointer; wraps naturally at address width.
  assign top      = sp - ONE_A;
  assign is_empty = (count == CW'(0));
  assign is_full  = (count == DEPTH_C);
  assign o_count  = count;
  assign o_empty  = is_empty;
  assign o_full   = is_full;
  assign o_tos    = is_empty ? {STACK_WIDTH{1'b0}} : mem[top];

  // Decode push/pop into pointer, memory-write, pop-data and error updates.
  always_comb begin
    sp_nxt        = sp;
    count_nxt     = count;
    wr_en         = 1'b0;
    wr_addr       = sp;
    pop_data_nxt  = o_pop_data;
    pop_valid_nxt = 1'b0;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    case ({i_push, i_pop})
      2'b10: begin
        if (!is_full) begin
          wr_en     = 1'b1;
          sp_nxt    = sp + ONE_A;
          count_nxt = count + ONE_C;
        end else if (WRAP_MODE != 0) begin
          // Circular: overwrite the oldest slot, occupancy stays at DEPTH.
          wr_en   = 1'b1;
          sp_nxt  = sp + ONE_A;
          ovf_set = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          pop_data_nxt  = mem[top];
          pop_valid_nxt = 1'b1;
          sp_nxt        = sp - ONE_A;
          count_nxt     = count - ONE_C;
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace: hand out the old top, store the new word in its place.
          pop_data_nxt  = mem[top];
          pop_valid_nxt = 1'b1;
          wr_en         = 1'b1;
          wr_addr       = top;
        end else begin
          // Bypass: the pushed word goes straight to the pop output.
          pop_data_nxt  = i_data;
          pop_valid_nxt = 1'b1;
        end
      end
      default: begin
        pop_valid_nxt = 1'b0;
      end
    endcase
  end

  // Pointer, occupancy, pop output and sticky error registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sp          <= '0;
      count       <= '0;
      o_pop_data  <= '0;
      o_pop_valid <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      sp          <= sp_nxt;
      count       <= count_nxt;
      o_pop_data  <= pop_data_nxt;
      o_pop_valid <= pop_valid_nxt;
      // A new error in the same cycle as a clear takes priority.
      if (ovf_set) begin
        o_overflow <= 1'b1;
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
      end
      if (unf_set) begin
        o_underflow <= 1'b1;
      end else if (i_clr_err) begin
        o_underflow <= 1'b0;
      end
    end
  end

  // Storage array; contents are not reset, writes are blocked while in reset.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) begin
      mem[wr_addr] <= i_data;
    end
  end

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int W  = 18;
  localparam int AB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [W-1:0]  data;

  logic [W-1:0]  pop_data_w, tos_w, pop_data_s, tos_s;
  logic          pop_valid_w, empty_w, full_w, ovf_w, unf_w;
  logic          pop_valid_s, empty_s, full_s, ovf_s, unf_s;
  logic [AB:0]   count_w, count_s;

  int checks = 0;
  int errors = 0;

  param_stack #(.STACK_WIDTH(W), .STACK_ADDR_BITS(AB), .WRAP_MODE(1)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_data(data),
    .i_clr_err(clr_err), .o_pop_data(pop_data_w), .o_pop_valid(pop_valid_w),
    .o_tos(tos_w), .o_count(count_w), .o_empty(empty_w), .o_full(full_w),
    .o_overflow(ovf_w), .o_underflow(unf_w)
  );

  param_stack #(.STACK_WIDTH(W), .STACK_ADDR_BITS(AB), .WRAP_MODE(0)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_data(data),
    .i_clr_err(clr_err), .o_pop_data(pop_data_s), .o_pop_valid(pop_valid_s),
    .o_tos(tos_s), .o_count(count_s), .o_empty(empty_s), .o_full(full_s),
    .o_overflow(ovf_s), .o_underflow(unf_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    data    = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    check("rst count_w", 32'(count_w), 32'd0);
    check("rst empty_w", 32'(empty_w), 32'd1);
    check("rst full_w", 32'(full_w), 32'd0);
    check("rst tos_w", 32'(tos_w), 32'd0);
    check("rst pop_data_w", 32'(pop_data_w), 32'd0);
    check("rst pop_valid_w", 32'(pop_valid_w), 32'd0);
    check("rst ovf_w", 32'(ovf_w), 32'd0);
    check("rst unf_w", 32'(unf_w), 32'd0);
    check("rst count_s", 32'(count_s), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic push 1,2,3 then pop x3.
    for (int i = 1; i <= 3; i++) begin
      push = 1'b1; data = W'(i);
      step();
    end
    idle();
    check("push3 count", 32'(count_w), 32'd3);
    check("push3 tos", 32'(tos_w), 32'd3);
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      step();
      check("pop3 data", 32'(pop_data_w), 32'(3 - i));
      check("pop3 valid", 32'(pop_valid_w), 32'd1);
    end
    idle();
    step();
    check("pop3 empty", 32'(empty_w), 32'd1);
    check("idle valid", 32'(pop_valid_w), 32'd0);
    check("empty tos", 32'(tos_w), 32'd0);

    // Underflow on empty, then clear.
    pop = 1'b1;
    step();
    idle();
    check("unf valid", 32'(pop_valid_w), 32'd0);
    check("unf flag", 32'(unf_w), 32'd1);
    check("unf count", 32'(count_w), 32'd0);
    clr_err = 1'b1;
    step();
    idle();
    check("unf cleared", 32'(unf_w), 32'd0);

    // Push 1..17: circular vs saturating.
    for (int i = 1; i <= 17; i++) begin
      push = 1'b1; data = W'(i);
      step();
    end
    idle();
    check("wrap full", 32'(full_w), 32'd1);
    check("wrap count", 32'(count_w), 32'd16);
    check("wrap ovf", 32'(ovf_w), 32'd1);
    check("wrap tos", 32'(tos_w), 32'd17);
    check("sat full", 32'(full_s), 32'd1);
    check("sat count", 32'(count_s), 32'd16);
    check("sat ovf", 32'(ovf_s), 32'd1);
    check("sat tos", 32'(tos_s), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      step();
      check("wrap pop data", 32'(pop_data_w), 32'(17 - i));
      check("sat pop data", 32'(pop_data_s), 32'(16 - i));
      check("wrap pop valid", 32'(pop_valid_w), 32'd1);
    end
    idle();
    check("wrap drained", 32'(empty_w), 32'd1);
    check("sat drained", 32'(empty_s), 32'd1);
    check("wrap no unf", 32'(unf_w), 32'd0);
    clr_err = 1'b1;
    step();
    idle();
    check("ovf cleared", 32'(ovf_w), 32'd0);

    // Replace and bypass.
    push = 1'b1; data = W'(18'h0000A);
    step();
    push = 1'b1; pop = 1'b1; data = W'(18'h0000B);
    step();
    idle();
    check("replace data", 32'(pop_data_w), 32'h0000A);
    check("replace valid", 32'(pop_valid_w), 32'd1);
    check("replace count", 32'(count_w), 32'd1);
    check("replace tos", 32'(tos_w), 32'h0000B);
    pop = 1'b1;
    step();
    idle();
    check("pop replaced", 32'(pop_data_w), 32'h0000B);
    push = 1'b1; pop = 1'b1; data = W'(18'h0000C);
    step();
    idle();
    check("bypass data", 32'(pop_data_w), 32'h0000C);
    check("bypass valid", 32'(pop_valid_w), 32'd1);
    check("bypass count", 32'(count_w), 32'd0);
    check("bypass no unf", 32'(unf_w), 32'd0);

    // Error set wins over same-cycle clear.
    pop = 1'b1; clr_err = 1'b1;
    step();
    idle();
    check("set wins", 32'(unf_w), 32'd1);

    // Push 5 words, then asynchronous reset between edges.
    for (int i = 1; i <= 5; i++) begin
      push = 1'b1; data = W'(i + 32'h100);
      step();
    end
    check("pre-rst count", 32'(count_w), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("async count", 32'(count_w), 32'd0);
    check("async empty", 32'(empty_w), 32'd1);
    check("async unf", 32'(unf_w), 32'd0);
    check("async ovf", 32'(ovf_w), 32'd0);
    check("async tos", 32'(tos_w), 32'd0);
    step();
    check("push in rst", 32'(count_w), 32'd0);
    rst = 1'b0;
    idle();
    step();
    check("post-rst count", 32'(count_w), 32'd0);
    check("post-rst empty", 32'(empty_s), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
